// File: rtl/reg_file_wb.sv
// reg_file_wb: register file with write-back port and per-register pending-write scoreboard
// Ports: clk; rst (async, active-low); src1/src2 -> reg1/reg2 combinational reads;
//   use_src2 qualifies src2 for hazard; issue_en/issue_wb/issue_dest mark a destination pending;
//   WB_EN/WB_Dest/WB_Value write back and retire one pending write; hazard asks decode to stall;
//   sb_overflow is a sticky flag for an issue to a saturated counter.
// Define REG_FILE_BYPASS_EN to forward a same-cycle write-back to reads and to the hazard check.
module reg_file_wb #(
  parameter int NREG = 32,
  parameter int DW = 32,
  parameter int CNT_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    src1,
  input  logic [4:0]    src2,
  input  logic          use_src2,
  output logic [DW-1:0] reg1,
  output logic [DW-1:0] reg2,
  input  logic          issue_en,
  input  logic          issue_wb,
  input  logic [4:0]    issue_dest,
  input  logic          WB_EN,
  input  logic [4:0]    WB_Dest,
  input  logic [DW-1:0] WB_Value,
  output logic          hazard,
  output logic          sb_overflow
);
  logic [DW-1:0] regs [NREG];
  logic [NREG-1:0][CNT_W-1:0] cnt, cnt_nxt;
  logic ovf;

  function automatic logic [DW-1:0] rd(input logic [4:0] x);
`ifdef REG_FILE_BYPASS_EN
    return x == '0 ? '0 : (WB_EN && WB_Dest == x) ? WB_Value : regs[x];
`else
    return x == '0 ? '0 : regs[x];
`endif
  endfunction

  // With forwarding, the last in-flight write landing this cycle no longer blocks the read.
  function automatic logic pend(input logic [4:0] x);
`ifdef REG_FILE_BYPASS_EN
    return x != '0 && cnt[x] > ((WB_EN && WB_Dest == x) ? CNT_W'(1) : CNT_W'(0));
`else
    return x != '0 && cnt[x] != '0;
`endif
  endfunction

  assign reg1 = rd(src1);
  assign reg2 = rd(src2);
  assign hazard = pend(src1) | (use_src2 & pend(src2));

  // R0 never gets a counter update, so the loop starts at 1.
  always_comb begin
    logic inc, dec;
    inc = 1'b0;
    dec = 1'b0;
    cnt_nxt = cnt;
    ovf = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      inc = issue_en && issue_wb && issue_dest == r[4:0];
      dec = WB_EN && WB_Dest == r[4:0] && cnt[r] != '0;
      if (inc && !dec) begin
        if (&cnt[r]) ovf = 1'b1;
        else cnt_nxt[r] = cnt[r] + CNT_W'(1);
      end else if (dec && !inc) cnt_nxt[r] = cnt[r] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      cnt <= '0;
      sb_overflow <= 1'b0;
    end else begin
      if (WB_EN && WB_Dest != '0) regs[WB_Dest] <= WB_Value;
      cnt <= cnt_nxt;
      sb_overflow <= sb_overflow | ovf;
    end
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: table, directed and randomized checks of reg_file_wb
module tb_reg_file_wb;
  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] src1, src2, issue_dest, WB_Dest;
  logic use_src2, issue_en, issue_wb, WB_EN;
  logic [31:0] WB_Value, reg1, reg2;
  logic hazard, sb_overflow;

  reg_file_wb dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .use_src2(use_src2),
    .reg1(reg1), .reg2(reg2), .issue_en(issue_en), .issue_wb(issue_wb),
    .issue_dest(issue_dest), .WB_EN(WB_EN), .WB_Dest(WB_Dest), .WB_Value(WB_Value),
    .hazard(hazard), .sb_overflow(sb_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] s1, s2;
    logic u2, ie, iw;
    logic [4:0] id;
    logic we;
    logic [4:0] wd;
    logic [31:0] wv, e1, e2;
    logic eh, eo;
  } vec_t;

  vec_t tv[15];
  int checks = 0, errors = 0;
  logic [31:0] m_regs[32];
  int m_cnt[32];
  logic m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    src1 = v.s1; src2 = v.s2; use_src2 = v.u2;
    issue_en = v.ie; issue_wb = v.iw; issue_dest = v.id;
    WB_EN = v.we; WB_Dest = v.wd; WB_Value = v.wv;
  endtask

  task automatic idle(input logic [4:0] a, input logic [4:0] b, input logic u);
    src1 = a; src2 = b; use_src2 = u;
    issue_en = 0; issue_wb = 0; issue_dest = 0;
    WB_EN = 0; WB_Dest = 0; WB_Value = 0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] x);
    if (x == 0) return 0;
`ifdef REG_FILE_BYPASS_EN
    if (WB_EN && WB_Dest == x) return WB_Value;
`endif
    return m_regs[x];
  endfunction

  function automatic logic m_pend(input logic [4:0] x);
    if (x == 0) return 0;
`ifdef REG_FILE_BYPASS_EN
    return m_cnt[x] > ((WB_EN && WB_Dest == x) ? 1 : 0);
`else
    return m_cnt[x] != 0;
`endif
  endfunction

  task automatic m_update;
    bit inc, dec;
    if (WB_EN && WB_Dest != 0) m_regs[WB_Dest] = WB_Value;
    for (int r = 1; r < 32; r++) begin
      inc = issue_en && issue_wb && issue_dest == r;
      dec = WB_EN && WB_Dest == r && m_cnt[r] > 0;
      if (inc && !dec) begin
        if (m_cnt[r] == 3) m_ovf = 1;
        else m_cnt[r]++;
      end else if (dec && !inc) m_cnt[r]--;
    end
  endtask

  initial begin
    //        s1 s2 u2 ie iw id we wd wv            e1            e2            eh eo
    tv[0]  = '{5, 0, 0, 0, 0, 0, 0, 0, 0,            0,            0,            0, 0};
    tv[1]  = '{5, 0, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 0,            0,            0, 0};
    tv[2]  = '{3, 0, 0, 0, 0, 0, 1, 0, 32'h1234,     32'hDEADBEEF, 0,            0, 0};
    tv[3]  = '{0, 3, 1, 1, 1, 0, 0, 0, 0,            0,            32'hDEADBEEF, 0, 0};
    tv[4]  = '{0, 0, 1, 1, 1, 7, 0, 0, 0,            0,            0,            0, 0};
    tv[5]  = '{0, 7, 1, 0, 0, 0, 0, 0, 0,            0,            0,            1, 0};
    tv[6]  = '{0, 7, 0, 0, 0, 0, 0, 0, 0,            0,            0,            0, 0};
    tv[7]  = '{1, 2, 1, 0, 0, 0, 1, 7, 32'h77,       0,            0,            0, 0};
    tv[8]  = '{0, 7, 1, 0, 0, 0, 0, 0, 0,            0,            32'h77,       0, 0};
    tv[9]  = '{0, 0, 0, 1, 1, 9, 0, 0, 0,            0,            0,            0, 0};
    tv[10] = '{0, 0, 0, 1, 1, 9, 1, 9, 32'h99,       0,            0,            0, 0};
    tv[11] = '{9, 0, 0, 1, 1, 9, 0, 0, 0,            32'h99,       0,            1, 0};
    tv[12] = '{9, 0, 0, 1, 1, 9, 0, 0, 0,            32'h99,       0,            1, 0};
    tv[13] = '{9, 0, 0, 1, 1, 9, 0, 0, 0,            32'h99,       0,            1, 0};
    tv[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,            0,            0,            0, 1};

    idle(5, 0, 1);
    #1;
    chk("reset_reg1", reg1, 0);
    chk("reset_reg2", reg2, 0);
    chk("reset_hazard", {31'b0, hazard}, 0);
    chk("reset_ovf", {31'b0, sb_overflow}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;

    for (int i = 0; i < 15; i++) begin
      drive(tv[i]);
      #3;
      chk($sformatf("tv%0d_reg1", i), reg1, tv[i].e1);
      chk($sformatf("tv%0d_reg2", i), reg2, tv[i].e2);
      chk($sformatf("tv%0d_hazard", i), {31'b0, hazard}, {31'b0, tv[i].eh});
      chk($sformatf("tv%0d_ovf", i), {31'b0, sb_overflow}, {31'b0, tv[i].eo});
      tick;
    end

    // Mid-operation async reset discards pending writes and data immediately.
    idle(0, 0, 0);
    issue_en = 1; issue_wb = 1; issue_dest = 10;
    tick;
    idle(10, 3, 1);
    #1;
    chk("pre_rst_hazard", {31'b0, hazard}, 1);
    rst = 0;
    #1;
    chk("mid_rst_hazard", {31'b0, hazard}, 0);
    chk("mid_rst_reg2", reg2, 0);
    chk("mid_rst_ovf", {31'b0, sb_overflow}, 0);
    #1 rst = 1;
    tick;

    // Final in-flight write landing in the same cycle as the read.
    idle(0, 0, 0);
    WB_EN = 1; WB_Dest = 4; WB_Value = 32'h11;
    issue_en = 1; issue_wb = 1; issue_dest = 4;
    tick;
    idle(4, 0, 0);
    WB_EN = 1; WB_Dest = 4; WB_Value = 32'h55;
    #3;
`ifdef REG_FILE_BYPASS_EN
    chk("byp_reg1", reg1, 32'h55);
    chk("byp_hazard", {31'b0, hazard}, 0);
`else
    chk("nobyp_reg1", reg1, 32'h11);
    chk("nobyp_hazard", {31'b0, hazard}, 1);
`endif
    tick;
    idle(4, 0, 0);
    #1;
    chk("after_wb_reg1", reg1, 32'h55);
    chk("after_wb_hazard", {31'b0, hazard}, 0);

    // Randomized run against the reference model from a clean reset.
    rst = 0;
    #1 rst = 1;
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 0;
      m_cnt[r] = 0;
    end
    m_ovf = 0;
    tick;
    for (int c = 0; c < 400; c++) begin
      src1 = 5'($urandom_range(0, 7));
      src2 = 5'($urandom_range(0, 7));
      use_src2 = 1'($urandom_range(0, 1));
      issue_en = ($urandom_range(0, 2) != 0);
      issue_wb = 1'($urandom_range(0, 1));
      issue_dest = 5'($urandom_range(0, 7));
      WB_EN = ($urandom_range(0, 2) != 0);
      WB_Dest = 5'($urandom_range(0, 7));
      WB_Value = $urandom;
      #3;
      chk("rnd_reg1", reg1, m_read(src1));
      chk("rnd_reg2", reg2, m_read(src2));
      chk("rnd_hazard", {31'b0, hazard}, {31'b0, m_pend(src1) | (use_src2 & m_pend(src2))});
      chk("rnd_ovf", {31'b0, sb_overflow}, {31'b0, m_ovf});
      tick;
      m_update;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Register file and write-back end of the 5-stage pipeline.
- Takes the source indices the decode stage drives (src1/src2) and returns operand values (reg1/reg2).
- Accepts the single write-back from WB.
- Keeps a per-register pending-write scoreboard fed by decode issue; raises a hazard signal so decode can stall instead of reading stale operands.

Parameters:
- NREG, 32, number of architectural registers; R0 is hardwired to zero.
- DW, 32, register data width.
- CNT_W, 2, width of the per-register pending counter; maximum in-flight writes per register is 2^CNT_W-1 = 3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- src1  in  5  read index A (decode src1).
- src2  in  5  read index B (decode src2).
- use_src2  in  1  src2 is a real operand (R-type, store, bne); qualifies hazard.
- reg1  out  DW  value of register src1.
- reg2  out  DW  value of register src2.
- issue_en  in  1  decode issues an instruction this cycle (not stalled, not flushed).
- issue_wb  in  1  issued instruction has WB_EN set.
- issue_dest  in  5  Dest of the issued instruction.
- WB_EN  in  1  write-back valid.
- WB_Dest  in  5  write-back register index.
- WB_Value  in  DW  write-back data.
- hazard  out  1  operand of the current decode is pending; decode must stall.
- sb_overflow  out  1  sticky error: issue attempted on a saturated counter.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers go to 0.
  - All pending counters go to 0.
  - sb_overflow goes to 0.
  - reg1/reg2 therefore read 0 and hazard is 0.
  - Reset asserted mid-operation discards every pending write immediately.
- Write: on the rising edge with WB_EN=1 and WB_Dest!=0, regs[WB_Dest] <= WB_Value. Writes to R0 are ignored.
- Read: combinational, zero latency.
  - reg1 = regs[src1], reg2 = regs[src2].
  - Index 0 always returns 0 regardless of bypass.
- Scoreboard update per register r, evaluated each rising edge:
  - inc = issue_en & issue_wb & (issue_dest==r) & (r!=0).
  - dec = WB_EN & (WB_Dest==r) & (r!=0) & (cnt[r]!=0).
  - inc&dec: cnt unchanged.
  - inc only: cnt+1. If cnt is at max, cnt holds and sb_overflow <= 1.
  - dec only: cnt-1.
  - A write-back to a register with cnt==0 still writes data; the counter does not underflow.
- Hazard (combinational):
  - hazard = pend(src1) | (use_src2 & pend(src2)).
  - pend(0) = 0.
  - pend(x) = (cnt[x]!=0), except as modified by the optional feature.
- No state machine beyond the counters. sb_overflow clears only on reset.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - Same-cycle forwarding: if WB_EN=1 and WB_Dest==srcN!=0, regN = WB_Value instead of the stored value.
  - pend(x) = (cnt[x] > (WB_EN & WB_Dest==x ? 1 : 0)), so the final in-flight write landing this cycle does not stall.
- Undefined:
  - Reads return the stored value only.
  - pend(x) = (cnt[x]!=0).
  - A source written back this cycle stalls one extra cycle.

Test Plan:
- Reset then read: rst low, src1=5, src2=0 -> reg1=0, reg2=0, hazard=0, sb_overflow=0.
- Write/read: WB_EN=1, WB_Dest=3, WB_Value=0xDEADBEEF for one edge; next cycle src1=3 -> reg1=0xDEADBEEF.
- R0 protection: WB_Dest=0, WB_Value=0x1234 -> src1=0 reads 0. Issue to dest 0 -> hazard stays 0.
- Scoreboard: issue dest=7 -> next cycle src2=7, use_src2=1 -> hazard=1. With use_src2=0 -> hazard=0. After WB_Dest=7 edge -> hazard=0.
- Simultaneous/saturation:
  - Issue and WB to reg 9 on the same edge with cnt=1 -> cnt stays 1.
  - Four issues to reg 9 with no WB -> cnt=3, sb_overflow=1.
- Bypass (REG_FILE_BYPASS_EN): cnt[4]=1, WB_Dest=4, WB_Value=0x55 in the same cycle as src1=4 -> reg1=0x55, hazard=0. Without the macro -> reg1 is the old value, hazard=1.
